// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MIPS-style HI/LO multiply/divide unit with fixed 34-cycle latency
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mult_en, div_en        MULT(U)/DIV(U) request (div_en wins if both set)
//   unsigned_instr         1 = MULTU/DIVU, 0 = signed
//   src_a, src_b           multiplicand/dividend, multiplier/divisor
//   hi_out, lo_out         product[63:32]/remainder, product[31:0]/quotient
//   busy                   high in CALC and FIX; requests ignored
//   done                   one-cycle completion pulse
//   div_by_zero            qualifies done: last division had a zero divisor
module hilo_muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        mult_en,
   input  logic        div_en,
   input  logic        unsigned_instr,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state, state_n;
   logic [63:0] acc;
   logic [31:0] opb;
   logic [5:0]  cnt;
   logic        is_div, neg_lo, neg_hi, dbz;
   logic        accept, sa, sb;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum, r_sh;
   logic [31:0] r_sub;
   logic        ge;
   logic [63:0] prod, mul_next, div_next;

   assign accept = (state == IDLE || state == DONE) && (mult_en || div_en);
   assign sa     = !unsigned_instr && src_a[31];
   assign sb     = !unsigned_instr && src_b[31];
   assign mag_a  = sa ? -src_a : src_a;
   assign mag_b  = sb ? -src_b : src_b;

   // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
   assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
   assign mul_next = {mul_sum, acc[31:1]};
   // restoring divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}
   assign r_sh     = {acc[63:32], acc[31]};
   assign ge       = r_sh >= {1'b0, opb};
   assign r_sub    = r_sh[31:0] - opb;
   assign div_next = {ge ? r_sub : r_sh[31:0], acc[30:0], ge};
   assign prod     = neg_lo ? -acc : acc;

   assign busy        = state == CALC || state == FIX;
   assign done        = state == DONE;
   assign div_by_zero = done && dbz;

   always_comb begin
      state_n = state;
      if (accept) state_n = CALC;
      else if (state == CALC) state_n = cnt == 6'd0 ? FIX : CALC;
      else if (state == FIX) state_n = DONE;
      else if (state == DONE) state_n = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         opb    <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         dbz    <= 1'b0;
         hi_out <= '0;
         lo_out <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            is_div <= div_en;
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            dbz    <= div_en && src_b == 32'd0;
            cnt    <= 6'd32;
            acc    <= {32'd0, div_en ? mag_a : mag_b};
            opb    <= div_en ? mag_b : mag_a;
         end else if (state == CALC && cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
            acc <= is_div ? div_next : mul_next;
         end else if (state == FIX) begin
            hi_out <= is_div ? (neg_hi ? -acc[63:32] : acc[63:32]) : prod[63:32];
            // a zero divisor yields an all-ones quotient magnitude; force it so sign fix-up cannot alter it
            lo_out <= is_div ? (dbz ? 32'hFFFF_FFFF : neg_lo ? -acc[31:0] : acc[31:0]) : prod[31:0];
         end
      end
   end
endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide port: mult_en  input  1  MULT/MULTU request from the decoder.
REQ-004 SHALL provide port: div_en  input  1  DIV/DIVU request from the decoder.
REQ-005 SHALL provide port: unsigned_instr  input  1  1 = MULTU/DIVU, 0 = signed MULT/DIV.
REQ-006 SHALL provide port: src_a  input  32  rs operand (multiplicand / dividend).
REQ-007 SHALL provide port: src_b  input  32  rt operand (multiplier / divisor).
REQ-008 SHALL provide port: hi_out  output  32  HI result (product[63:32] / remainder).
REQ-009 SHALL provide port: lo_out  output  32  LO result (product[31:0] / quotient).
REQ-010 SHALL provide port: busy  output  1  operation in progress; requests ignored.
REQ-011 SHALL provide port: done  output  1  one-cycle pulse; hi_out/lo_out hold the new result.
REQ-012 SHALL provide port: div_by_zero  output  1  qualifies done; last division had src_b = 0.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-014 SHALL accept a request when state is IDLE or DONE and mult_en or div_en = 1: latch src_a, src_b, op type and unsigned_instr; load counter = 32; go to CALC.
REQ-015 SHALL give div_en priority when mult_en and div_en are both 1 in the accepting cycle.
REQ-016 SHALL ignore mult_en/div_en in CALC and FIX (no queueing); latched operands unaffected.
REQ-017 SHALL in signed mode convert both operands to magnitudes at acceptance and record result signs.
REQ-018 SHALL in CALC perform one iteration per cycle for exactly 32 cycles, then go to FIX:
- multiply: shift-add, 64-bit accumulator
- divide: restoring, 1 quotient bit per cycle
REQ-019 SHALL in FIX (1 cycle) apply signs and register results into hi_out/lo_out, then go to DONE:
- product negated if operand signs differ
- quotient truncates toward zero
- remainder takes the dividend's sign
REQ-020 SHALL assert done = 1 only in DONE; DONE lasts 1 cycle, then IDLE unless a new request is accepted.
REQ-021 SHALL produce fixed latency: request sampled at edge k gives done = 1 in the cycle after edge k+34, for every operation including divide-by-zero.
REQ-022 SHALL assert busy = 1 in CALC and FIX only; busy = 0 in IDLE and DONE.
REQ-023 SHALL on divide with src_b = 0 complete with hi_out = original src_a, lo_out = 0xFFFFFFFF, div_by_zero = 1 during done; otherwise div_by_zero = 0.
REQ-024 SHALL on signed 0x80000000 / 0xFFFFFFFF produce lo_out = 0x80000000, hi_out = 0x00000000, with no error flag.
REQ-025 SHALL hold hi_out/lo_out stable between FIX updates.

Reset
REQ-026 SHALL on rst = 1 at any edge, including mid-operation:
- state to IDLE
- abort any operation with no done
- busy, done, div_by_zero, hi_out, lo_out, accumulators and counter to 0
REQ-027 SHALL ignore mult_en/div_en in any cycle where rst = 1.

Verification
REQ-028 SHALL cover: MULT with src_a = 0xFFFFFFFD, src_b = 0x00000007 -> hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB, done exactly 34 cycles after the request edge.
REQ-029 SHALL cover: MULTU with 0xFFFFFFFF x 0xFFFFFFFF -> hi_out = 0xFFFFFFFE, lo_out = 0x00000001.
REQ-030 SHALL cover: DIV -7/2 -> lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF; DIVU 7/2 -> lo_out = 3, hi_out = 1; back-to-back with the second request issued in the DONE cycle.
REQ-031 SHALL cover: DIV 0x12345678/0 -> hi_out = 0x12345678, lo_out = 0xFFFFFFFF, div_by_zero = 1 with done.
REQ-032 SHALL cover: signed 0x80000000 / 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0.
REQ-033 SHALL cover: mult_en pulsed while busy -> ignored; rst asserted 10 cycles into CALC -> next cycle busy = 0, hi_out = lo_out = 0, no done pulse.
